// File: rtl/axi_strobe_pkg.sv
// Shared definitions for the AXI4-Lite strobe/ack register block: register
// offsets, AXI response codes, FSM states and STATUS bit positions.
package axi_strobe_pkg;

  localparam logic [1:0] REG_FIR_ADDR  = 2'd0;
  localparam logic [1:0] REG_FIR_COEFF = 2'd1;
  localparam logic [1:0] REG_HIST_BIN  = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_STB,
    ST_WR_RSP,
    ST_RD_STB,
    ST_RD_RSP
  } state_t;

  // Byte-lane merge of a write beat into an existing 32-bit value.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/strobe_timeout_ctr.sv
// Load/run/expire down-counter bounding how long a strobe waits for its ack.
// expired is asserted in the CYCLES-th run cycle after a load.
module strobe_timeout_ctr #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(CYCLES - 1);
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = run && (count == '0);

endmodule

// File: rtl/axi_strobe_regs.sv
// AXI4-Lite slave that turns register accesses into FIR coefficient write
// strobes and histogram read strobes. Optional macro: STROBE_ADDR_AUTOINC_EN.
//
// state     | meaning
// ST_IDLE   | collecting AW/W beats or an AR beat
// ST_WR_STB | coefficient write strobe high, waiting for ack or timeout
// ST_WR_RSP | B response presented, waiting for bready
// ST_RD_STB | histogram read strobe high, waiting for ack or timeout
// ST_RD_RSP | R response presented, waiting for rready
module axi_strobe_regs
  import axi_strobe_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int FIR_ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              axi_wr_strobe_o,
  input  logic              axi_wr_ack_i,
  output logic              axi_rd_strobe_o,
  input  logic              axi_rd_ack_i,
  output logic [31:0]       fir_addr_o,
  output logic [31:0]       fir_coeff_o,
  input  logic [31:0]       hist_bin_i,
  output logic              busy_o
);

`ifdef STROBE_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_t                  state;
  logic                    rdy_en;
  logic                    aw_done;
  logic                    w_done;
  logic [ADDR_W-1:0]       awaddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic [FIR_ADDR_W-1:0]   fir_addr_q;
  logic [31:0]             fir_coeff_q;
  logic                    timeout_sticky;

  logic                    idle;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic                    aw_have;
  logic                    w_have;
  logic                    wr_fire;
  logic [ADDR_W-1:0]       wr_addr;
  logic [31:0]             wr_data;
  logic [3:0]              wr_strb;
  logic [1:0]              wr_idx;
  logic [1:0]              rd_idx;
  logic [31:0]             addr_merge;
  logic [31:0]             status_word;
  logic [31:0]             rd_reg_data;
  logic                    tmr_load;
  logic                    tmr_expired;
  logic                    unused_bits;

  assign idle  = (state == ST_IDLE);
  assign busy_o = (state == ST_WR_STB) || (state == ST_RD_STB);

  // rdy_en keeps every ready low while rst is held and for the reset cycle.
  // AR is refused while any write beat is pending or offered so writes win.
  assign s_axi_awready = rdy_en && idle && !aw_done;
  assign s_axi_wready  = rdy_en && idle && !w_done;
  assign s_axi_arready = rdy_en && idle && !aw_done && !w_done &&
                         !s_axi_awvalid && !s_axi_wvalid;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign aw_have = aw_done || aw_hs;
  assign w_have  = w_done || w_hs;
  assign wr_fire = idle && aw_have && w_have;

  assign wr_addr = aw_done ? awaddr_q : s_axi_awaddr;
  assign wr_data = w_done ? wdata_q : s_axi_wdata;
  assign wr_strb = w_done ? wstrb_q : s_axi_wstrb;
  assign wr_idx  = wr_addr[3:2];
  assign rd_idx  = s_axi_araddr[3:2];

  assign fir_addr_o  = 32'(fir_addr_q);
  assign fir_coeff_o = fir_coeff_q;
  assign addr_merge  = apply_wstrb(fir_addr_o, wr_data, wr_strb);

  assign tmr_load = (wr_fire && (wr_idx == REG_FIR_COEFF)) ||
                    (ar_hs && (rd_idx == REG_HIST_BIN));

  assign unused_bits = ^{wr_addr[1:0], s_axi_araddr[1:0], addr_merge};

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY_BIT]    = busy_o;
    status_word[STATUS_TIMEOUT_BIT] = timeout_sticky;
  end

  always_comb begin
    rd_reg_data = '0;
    case (rd_idx)
      REG_FIR_ADDR:  rd_reg_data = fir_addr_o;
      REG_FIR_COEFF: rd_reg_data = fir_coeff_q;
      REG_STATUS:    rd_reg_data = status_word;
      default:       rd_reg_data = '0;
    endcase
  end

  strobe_timeout_ctr #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .run     (busy_o),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      rdy_en          <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      fir_addr_q      <= '0;
      fir_coeff_q     <= '0;
      timeout_sticky  <= 1'b0;
      s_axi_bvalid    <= 1'b0;
      s_axi_bresp     <= RESP_OKAY;
      s_axi_rvalid    <= 1'b0;
      s_axi_rresp     <= RESP_OKAY;
      s_axi_rdata     <= '0;
      axi_wr_strobe_o <= 1'b0;
      axi_rd_strobe_o <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (wr_fire) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            case (wr_idx)
              REG_FIR_ADDR: begin
                fir_addr_q   <= addr_merge[FIR_ADDR_W-1:0];
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= RESP_OKAY;
                state        <= ST_WR_RSP;
              end
              REG_FIR_COEFF: begin
                fir_coeff_q     <= apply_wstrb(fir_coeff_q, wr_data, wr_strb);
                axi_wr_strobe_o <= 1'b1;
                state           <= ST_WR_STB;
              end
              REG_STATUS: begin
                if (wr_strb[0] && wr_data[STATUS_TIMEOUT_BIT]) timeout_sticky <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= RESP_OKAY;
                state        <= ST_WR_RSP;
              end
              default: begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= RESP_OKAY;
                state        <= ST_WR_RSP;
              end
            endcase
          end else begin
            aw_done <= aw_have;
            w_done  <= w_have;
            if (aw_hs) awaddr_q <= s_axi_awaddr;
            if (w_hs) begin
              wdata_q <= s_axi_wdata;
              wstrb_q <= s_axi_wstrb;
            end
            if (ar_hs) begin
              if (rd_idx == REG_HIST_BIN) begin
                axi_rd_strobe_o <= 1'b1;
                state           <= ST_RD_STB;
              end else begin
                s_axi_rdata  <= rd_reg_data;
                s_axi_rresp  <= RESP_OKAY;
                s_axi_rvalid <= 1'b1;
                state        <= ST_RD_RSP;
              end
            end
          end
        end
        ST_WR_STB: begin
          if (axi_wr_ack_i) begin
            axi_wr_strobe_o <= 1'b0;
            s_axi_bvalid    <= 1'b1;
            s_axi_bresp     <= RESP_OKAY;
            if (AUTOINC) fir_addr_q <= fir_addr_q + 1'b1;
            state           <= ST_WR_RSP;
          end else if (tmr_expired) begin
            axi_wr_strobe_o <= 1'b0;
            timeout_sticky  <= 1'b1;
            s_axi_bvalid    <= 1'b1;
            s_axi_bresp     <= RESP_SLVERR;
            state           <= ST_WR_RSP;
          end
        end
        ST_RD_STB: begin
          if (axi_rd_ack_i) begin
            axi_rd_strobe_o <= 1'b0;
            s_axi_rdata     <= hist_bin_i;
            s_axi_rresp     <= RESP_OKAY;
            s_axi_rvalid    <= 1'b1;
            if (AUTOINC) fir_addr_q <= fir_addr_q + 1'b1;
            state           <= ST_RD_RSP;
          end else if (tmr_expired) begin
            axi_rd_strobe_o <= 1'b0;
            timeout_sticky  <= 1'b1;
            s_axi_rdata     <= '0;
            s_axi_rresp     <= RESP_SLVERR;
            s_axi_rvalid    <= 1'b1;
            state           <= ST_RD_RSP;
          end
        end
        ST_WR_RSP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        ST_RD_RSP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_strobe_regs.sv
// Randomized self-checking bench for axi_strobe_regs against a register-level
// reference model; honours STROBE_ADDR_AUTOINC_EN when defined.
module tb_axi_strobe_regs;

  localparam int T   = 16;
  localparam int FAW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        axi_wr_strobe_o;
  logic        axi_wr_ack_i = 1'b0;
  logic        axi_rd_strobe_o;
  logic        axi_rd_ack_i = 1'b0;
  logic [31:0] fir_addr_o;
  logic [31:0] fir_coeff_o;
  logic [31:0] hist_bin_i = '0;
  logic        busy_o;

  axi_strobe_regs #(
    .ADDR_W         (4),
    .TIMEOUT_CYCLES (T),
    .FIR_ADDR_W     (FAW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axi_awaddr    (s_axi_awaddr),
    .s_axi_awvalid   (s_axi_awvalid),
    .s_axi_awready   (s_axi_awready),
    .s_axi_wdata     (s_axi_wdata),
    .s_axi_wstrb     (s_axi_wstrb),
    .s_axi_wvalid    (s_axi_wvalid),
    .s_axi_wready    (s_axi_wready),
    .s_axi_bresp     (s_axi_bresp),
    .s_axi_bvalid    (s_axi_bvalid),
    .s_axi_bready    (s_axi_bready),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .axi_wr_strobe_o (axi_wr_strobe_o),
    .axi_wr_ack_i    (axi_wr_ack_i),
    .axi_rd_strobe_o (axi_rd_strobe_o),
    .axi_rd_ack_i    (axi_rd_ack_i),
    .fir_addr_o      (fir_addr_o),
    .fir_coeff_o     (fir_coeff_o),
    .hist_bin_i      (hist_bin_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: architectural register contents
  logic [31:0] m_addr   = '0;
  logic [31:0] m_coeff  = '0;
  logic        m_sticky = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Per-transaction observations
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  int          r_wcnt, r_rcnt, r_bbeats, r_rbeats;
  bit          r_done_all, r_order_err, r_valid_drop, r_ready_err, r_stable_err, r_busy_err;
  bit          r_b_after, r_r_after;

  task automatic xfer(input bit do_wr, input logic [3:0] waddr, input logic [31:0] wdat,
                      input logic [3:0] wstb, input int aw_at, input int w_at,
                      input bit do_rd, input logic [3:0] raddr, input int ar_at,
                      input int ack_dly, input int bdly, input int rdly, input logic [31:0] hist);
    bit aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    bit aw_sent = 0, w_sent = 0, ar_sent = 0, b_done = 0, r_done = 0, b_seen = 0, r_seen = 0;
    int bwait = 0, rwait = 0;
    logic [31:0] a_snap = '0, c_snap = '0;
    r_wcnt = 0; r_rcnt = 0; r_bbeats = 0; r_rbeats = 0; r_bresp = 2'b11; r_rresp = 2'b11;
    r_rdata = 32'hDEAD_BEEF; r_done_all = 0; r_order_err = 0; r_valid_drop = 0;
    r_ready_err = 0; r_stable_err = 0; r_busy_err = 0; r_b_after = 0; r_r_after = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (aw_hs) begin s_axi_awvalid = 0; aw_sent = 1; end
      if (w_hs) begin s_axi_wvalid = 0; w_sent = 1; end
      if (ar_hs) begin s_axi_arvalid = 0; ar_sent = 1; if (do_wr && !b_done) r_order_err = 1; end
      if (b_hs) begin s_axi_bready = 0; b_done = 1; r_bbeats++; end
      if (r_hs) begin s_axi_rready = 0; r_done = 1; r_rbeats++; end
      if ((!do_wr || b_done) && (!do_rd || r_done)) begin
        r_done_all = 1;
        r_b_after = s_axi_bvalid;
        r_r_after = s_axi_rvalid;
        break;
      end
      if (busy_o !== (axi_wr_strobe_o || axi_rd_strobe_o)) r_busy_err = 1;
      if ((axi_wr_strobe_o || axi_rd_strobe_o || s_axi_bvalid || s_axi_rvalid) &&
          (s_axi_awready || s_axi_wready || s_axi_arready)) r_ready_err = 1;
      // filter side: ack on the Nth strobe cycle, stray acks while no strobe
      hist_bin_i = $urandom;
      axi_wr_ack_i = !axi_wr_strobe_o && ($urandom_range(0, 3) == 0);
      axi_rd_ack_i = !axi_rd_strobe_o && ($urandom_range(0, 3) == 0);
      if (axi_wr_strobe_o || axi_rd_strobe_o) begin
        if (r_wcnt == 0 && r_rcnt == 0) begin a_snap = fir_addr_o; c_snap = fir_coeff_o; end
        else if (fir_addr_o !== a_snap || fir_coeff_o !== c_snap) r_stable_err = 1;
      end
      if (axi_wr_strobe_o) begin
        r_wcnt++;
        axi_wr_ack_i = (r_wcnt == ack_dly);
      end
      if (axi_rd_strobe_o) begin
        r_rcnt++;
        axi_rd_ack_i = (r_rcnt == ack_dly);
        if (axi_rd_ack_i) hist_bin_i = hist;
      end
      if (s_axi_bvalid) begin
        b_seen = 1; r_bresp = s_axi_bresp;
        if (bwait >= bdly) s_axi_bready = 1;
        bwait++;
      end else if (b_seen && !b_done) r_valid_drop = 1;
      if (s_axi_rvalid) begin
        r_seen = 1; r_rresp = s_axi_rresp; r_rdata = s_axi_rdata;
        if (rwait >= rdly) s_axi_rready = 1;
        rwait++;
      end else if (r_seen && !r_done) r_valid_drop = 1;
      if (do_wr && !aw_sent && cyc >= aw_at) begin s_axi_awaddr = waddr; s_axi_awvalid = 1; end
      if (do_wr && !w_sent && cyc >= w_at) begin
        s_axi_wdata = wdat; s_axi_wstrb = wstb; s_axi_wvalid = 1;
      end
      if (do_rd && !ar_sent && cyc >= ar_at) begin s_axi_araddr = raddr; s_axi_arvalid = 1; end
      #1;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      ar_hs = s_axi_arvalid && s_axi_arready;
      b_hs  = s_axi_bvalid && s_axi_bready;
      r_hs  = s_axi_rvalid && s_axi_rready;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    s_axi_bready = 0; s_axi_rready = 0; axi_wr_ack_i = 0; axi_rd_ack_i = 0;
  endtask

  task automatic txn(input bit do_wr, input logic [3:0] waddr, input logic [31:0] wdat,
                     input logic [3:0] wstb, input int aw_at, input int w_at,
                     input bit do_rd, input logic [3:0] raddr, input int ar_at,
                     input int ack_dly, input int bdly, input int rdly, input logic [31:0] hist);
    bit acked;
    int exp_cnt;
    logic [1:0] exp_resp;
    logic [31:0] exp_data;
    acked = (ack_dly >= 1) && (ack_dly <= T);
    xfer(do_wr, waddr, wdat, wstb, aw_at, w_at, do_rd, raddr, ar_at, ack_dly, bdly, rdly, hist);
    chk("xfer_done", 32'(r_done_all), 32'd1);
    if (do_wr) begin
      exp_cnt = 0; exp_resp = 2'b00;
      case (waddr[3:2])
        2'd0: m_addr = merge(m_addr, wdat, wstb) & 32'hFF;
        2'd1: begin
          m_coeff = merge(m_coeff, wdat, wstb);
          if (acked) begin
            exp_cnt = ack_dly;
`ifdef STROBE_ADDR_AUTOINC_EN
            m_addr = (m_addr + 1) & 32'hFF;
`endif
          end else begin
            exp_cnt = T; exp_resp = 2'b10; m_sticky = 1;
          end
        end
        2'd3: if (wstb[0] && wdat[1]) m_sticky = 0;
        default: ;
      endcase
      chk("bresp", 32'(r_bresp), 32'(exp_resp));
      chk("wr_strobe_cycles", r_wcnt, exp_cnt);
      chk("b_beats", {r_bbeats[30:0], r_b_after}, {31'd1, 1'b0});
    end
    if (do_rd) begin
      exp_cnt = 0; exp_resp = 2'b00; exp_data = '0;
      case (raddr[3:2])
        2'd0: exp_data = m_addr;
        2'd1: exp_data = m_coeff;
        2'd2: begin
          if (acked) begin
            exp_cnt = ack_dly; exp_data = hist;
`ifdef STROBE_ADDR_AUTOINC_EN
            m_addr = (m_addr + 1) & 32'hFF;
`endif
          end else begin
            exp_cnt = T; exp_resp = 2'b10; m_sticky = 1;
          end
        end
        default: exp_data = {30'd0, m_sticky, 1'b0};
      endcase
      chk("rresp", 32'(r_rresp), 32'(exp_resp));
      chk("rdata", r_rdata, exp_data);
      chk("rd_strobe_cycles", r_rcnt, exp_cnt);
      chk("r_beats", {r_rbeats[30:0], r_r_after}, {31'd1, 1'b0});
    end
    chk("fir_addr_o", fir_addr_o, m_addr);
    chk("fir_coeff_o", fir_coeff_o, m_coeff);
    chk("protocol_flags", {26'd0, r_order_err, r_valid_drop, r_ready_err, r_stable_err,
                           r_busy_err, 1'b0}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, awat, wat, arat;
    bit ok;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {22'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                       s_axi_rvalid, axi_wr_strobe_o, axi_rd_strobe_o, busy_o, s_axi_bresp == 2'b00,
                       s_axi_rresp == 2'b00}, 32'h3);
    chk("reset_rdata", s_axi_rdata, 32'd0);
    chk("reset_fir_addr", fir_addr_o, 32'd0);
    chk("reset_fir_coeff", fir_coeff_o, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_reset", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

    // Directed scenarios
    txn(1, 4'h0, 32'h05, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    txn(1, 4'h4, 32'h1234, 4'hF, 0, 0, 0, 4'h0, 0, 3, 0, 0, 0);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h8, 0, 5, 0, 0, 32'hABCD);
    txn(1, 4'h4, 32'h5555_AAAA, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'hC, 0, 0, 0, 0, 0);
    txn(1, 4'hC, 32'h2, 4'h1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'hC, 0, 0, 0, 0, 0);
    txn(1, 4'h4, 32'hCAFE_0001, 4'hF, 4, 0, 1, 4'h8, 4, 2, 0, 0, 32'h0BAD_F00D);
    txn(1, 4'h4, 32'h0000_7777, 4'h3, 0, 0, 0, 4'h0, 0, 2, 10, 0, 0);
    txn(1, 4'h4, 32'h1111_2222, 4'hF, 0, 0, 0, 4'h0, 0, T, 0, 0, 0);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h8, 0, T, 0, 3, 32'h600D_0016);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h8, 0, 0, 0, 0, 0);
    txn(1, 4'h8, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    txn(1, 4'h0, 32'hFF, 4'hF, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    txn(1, 4'h4, 32'h9999, 4'hF, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      awat = $urandom_range(0, 3);
      wat  = $urandom_range(0, 3);
      arat = (kind == 2) ? ((awat < wat ? awat : wat) + $urandom_range(0, 3)) : $urandom_range(0, 3);
      txn(kind != 1, {2'($urandom_range(0, 3)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
          awat, wat, kind != 0, {2'($urandom_range(0, 3)), 2'b00}, arat,
          $urandom_range(0, T + 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset in the middle of a coefficient strobe
    @(negedge clk);
    s_axi_awaddr = 4'h4; s_axi_awvalid = 1;
    s_axi_wdata = 32'h7E57_0000; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    axi_wr_ack_i = 0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_wr_strobe_o) begin ok = 1; break; end
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("mid_rst_strobe_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ctrl", {23'd0, s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                         s_axi_rvalid, axi_wr_strobe_o, axi_rd_strobe_o, busy_o}, 32'd0);
    chk("mid_rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    chk("mid_rst_rdata", s_axi_rdata, 32'd0);
    chk("mid_rst_fir_addr", fir_addr_o, 32'd0);
    chk("mid_rst_fir_coeff", fir_coeff_o, 32'd0);
    rst = 0;
    m_addr = '0; m_coeff = '0; m_sticky = 0;
    @(negedge clk);
    txn(0, 4'h0, 0, 4'h0, 0, 0, 1, 4'hC, 0, 0, 0, 0, 0);
    txn(1, 4'h4, 32'h0102_0304, 4'hF, 0, 0, 1, 4'h4, 0, 4, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_strobe_regs.md
Name: axi_strobe_regs

Overview:
- AXI4-Lite slave register block: the bus-facing initiator end of the strobe/ack register handshake used by the sobel pipeline (axi_wr_strobe/axi_wr_ack, axi_rd_strobe/axi_rd_ack, fir_addr, fir_coeff, hist_bin).
- Translates CPU register writes into FIR coefficient write strobes.
- Translates CPU reads into histogram-bin read strobes.
- Holds the AXI response until the filter side acks or a timeout fires. Sits between the CPU system AXI interconnect and sobel_top, single clock domain.

Parameters:
- ADDR_W, 4, AXI byte-address width decoded (4 registers, 32-bit, word aligned).
- TIMEOUT_CYCLES, 1024, max cycles a strobe waits for ack before error.
- FIR_ADDR_W, 8, significant bits of fir_addr_o; upper bits read 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1
- s_axi_wdata  in  32 / s_axi_wstrb  in  4 / s_axi_wvalid  in  1 / s_axi_wready  out  1
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_W / s_axi_arvalid  in  1 / s_axi_arready  out  1
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1
- axi_wr_strobe_o  out  1  coefficient write request to filter
- axi_wr_ack_i  in  1  filter accepted write
- axi_rd_strobe_o  out  1  histogram read request
- axi_rd_ack_i  in  1  hist_bin_i valid
- fir_addr_o  out  32  coefficient / histogram bin index
- fir_coeff_o  out  32  coefficient data
- hist_bin_i  in  32  histogram bin value
- busy_o  out  1  strobe outstanding

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: all ready/valid outputs 0; strobes 0; fir_addr_o, fir_coeff_o 0; bresp/rresp 0; rdata 0; busy_o 0; timeout sticky 0; FSM IDLE.
- Register map (awaddr/araddr[3:2]):
  - 0x0 FIR_ADDR RW, plain register.
  - 0x4 FIR_COEFF RW; a write launches a write strobe.
  - 0x8 HIST_BIN RO; a read launches a read strobe at index FIR_ADDR.
  - 0xC STATUS: bit0 busy, bit1 timeout sticky (write 1 clears), others 0.
- wstrb applies per byte to FIR_ADDR, FIR_COEFF and STATUS clear. Writes to 0x8 are ignored with OKAY.
- AW and W channels:
  - Accepted independently, each ready high in IDLE until its beat is captured.
  - Write proceeds when both are captured. No second beat is accepted before B completes.
- FSM states: IDLE, WR_STB, WR_RSP, RD_STB, RD_RSP.
  - IDLE with write complete:
    - Addr 0x4 -> WR_STB: fir_coeff_o updated same edge, axi_wr_strobe_o=1 next cycle.
    - Other addresses -> WR_RSP directly (1-cycle register write).
  - IDLE with AR captured:
    - Addr 0x8 -> RD_STB, axi_rd_strobe_o=1.
    - Other addresses -> RD_RSP with register data.
  - Simultaneous pending write and read: write wins; AR is held unaccepted (arready=0) until write response completes.
  - WR_STB/RD_STB:
    - Strobe held high until ack sampled high. Strobe drops the cycle after ack, then WR_RSP/RD_RSP.
    - On RD ack, rdata<=hist_bin_i captured in the ack cycle.
    - Ack while no strobe pending is ignored.
  - Timeout counter starts at strobe assertion. After TIMEOUT_CYCLES cycles without ack:
    - Strobe drops and sticky bit1 is set.
    - Response is SLVERR (2'b10); rdata=0 for reads.
  - WR_RSP/RD_RSP: bvalid/rvalid held until bready/rready, then IDLE. Valid must not drop before the handshake.
- busy_o = state in {WR_STB, RD_STB}.
- fir_addr_o/fir_coeff_o stable throughout the strobe. They change only on a captured AXI write.
- Reset mid-transaction: immediate return to reset values; the pending AXI transaction is abandoned.

Optional Feature:
- Macro STROBE_ADDR_AUTOINC_EN.
- Defined: after every successfully acked FIR_COEFF write or HIST_BIN read, FIR_ADDR increments by 1, wrapping modulo 2^FIR_ADDR_W. No increment on timeout.
- Undefined: FIR_ADDR changes only on direct writes.

Decomposition:
- Shared package axi_strobe_pkg:
  - register offset localparams;
  - AXI response codes OKAY/SLVERR;
  - FSM state enum;
  - STATUS bit positions.
- One natural sub-module, strobe_timeout_ctr (load/run/expire counter), reused for both strobe types.

Test Plan:
- Write 0x0=0x05, then 0x4=0x1234, ack after 3 cycles -> fir_addr_o=0x05, fir_coeff_o=0x1234, wr_strobe high 3 cycles, bresp=OKAY, single B beat.
- Read 0x8, ack with hist_bin_i=0xABCD after 5 cycles -> rd_strobe high until ack, rdata=0xABCD, rresp=OKAY.
- Write 0x4 with ack never asserted, TIMEOUT_CYCLES=16 -> strobe drops after 16 cycles, bresp=SLVERR, STATUS read=0x2; write 0xC=0x2 -> STATUS=0.
- Present W 4 cycles before AW, and AR same cycle as AW -> write completes first, arready stays 0 until B handshake, then read serviced.
- bready held low 10 cycles after write ack -> bvalid stays high, no new AW accepted; rst asserted mid-WR_STB -> all outputs zero next cycle.
- With STROBE_ADDR_AUTOINC_EN: FIR_ADDR=0xFF, coeff write acked -> FIR_ADDR reads 0x00.
